// File: rtl/fft_frame_ctrl_pkg.sv
// rtl/fft_frame_ctrl_pkg.sv - shared FSM state encoding and bit-reverse helper for the FFT frame sequencer
package fft_ctrl_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] UNLOAD = 3'd4;

    // Reverses the low 'size' bits of v; bits above 'size' come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int size);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            if (k < size) r[k] = v[size-1-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// rtl/fft_frame_ctrl_if.sv - sample input stream and result output stream of the FFT frame sequencer
interface fft_frame_ctrl_if #(
    parameter int bit_width = 24
);
    logic                 s_valid;
    logic                 s_ready;
    logic [bit_width-1:0] s_re;
    logic [bit_width-1:0] s_im;
    logic                 m_valid;
    logic                 m_ready;
    logic [bit_width-1:0] m_re;
    logic [bit_width-1:0] m_im;

    modport master (
        output s_valid, s_re, s_im, m_ready,
        input  s_ready, m_valid, m_re, m_im
    );

    modport slave (
        input  s_valid, s_re, s_im, m_ready,
        output s_ready, m_valid, m_re, m_im
    );
endinterface

// File: rtl/fft_out_skid.sv
// rtl/fft_out_skid.sv - 2-entry valid/ready result buffer reporting free space
module fft_out_skid #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic [1:0]   space
);
    logic [W-1:0] re_q [2];
    logic [W-1:0] im_q [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         pop;

    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_re    = re_q[rd_ptr];
    assign out_im    = im_q[rd_ptr];
    assign space     = 2'd2 - count;

    // A push while full is only ever paired with a pop, so the slot being overwritten is the one leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (in_valid) begin
                re_q[wr_ptr] <= in_re;
                im_q[wr_ptr] <= in_im;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, in_valid} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - FFT frame sequencer: bit-reversed load, start, drain; watchdog under FFT_FRAME_TIMEOUT_EN
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int bit_width   = 24,
    parameter int N           = 16,
    parameter int SIZE        = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_frame_ctrl_if.slave      bus,
    output logic                 fft_load,
    output logic                 fft_start,
    output logic [SIZE-1:0]      fft_addr,
    output logic [bit_width-1:0] fft_re,
    output logic [bit_width-1:0] fft_im,
    output logic                 fft_en_out,
    input  logic                 fft_en_o,
    input  logic                 fft_done,
    input  logic [bit_width-1:0] fft_re_o,
    input  logic [bit_width-1:0] fft_im_o,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_timeout
);
    logic [2:0]      state;
    logic [SIZE-1:0] cnt;
    logic [SIZE:0]   issued;
    logic            inflight;
    logic [1:0]      space;
    logic            accept;
    logic            pop;
    logic            push;
    logic            wait_expired;

    assign bus.s_ready = (state == IDLE) || (state == LOAD);
    assign accept      = bus.s_valid && bus.s_ready;
    assign pop         = bus.m_valid && bus.m_ready;
    assign push        = fft_en_o && (state == UNLOAD);
    assign busy        = (state != IDLE);
    assign frame_done  = (state == UNLOAD) && pop && (cnt == SIZE'(N-1));

    // Request another result only if it will find a free slot: occupancy plus the result
    // already in flight, minus the one leaving this cycle, must be at most one.
    assign fft_en_out = (state == UNLOAD) && (issued < (SIZE+1)'(N)) &&
                        (({1'b0, space} + {2'b0, pop}) > {2'b0, inflight});

    fft_out_skid #(.W(bit_width)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_re     (fft_re_o),
        .in_im     (fft_im_o),
        .out_valid (bus.m_valid),
        .out_ready (bus.m_ready),
        .out_re    (bus.m_re),
        .out_im    (bus.m_im),
        .space     (space)
    );

`ifdef FFT_FRAME_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WCNT_W-1:0] wcnt;
    logic              err_q;

    assign wait_expired = (state == WAIT) && !fft_done && (wcnt == WCNT_W'(TIMEOUT_CYC - 1));
    assign err_timeout  = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
            if (wait_expired)
                err_q <= 1'b1;
            else if (state == IDLE && accept)
                err_q <= 1'b0;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign err_timeout  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            issued    <= '0;
            inflight  <= 1'b0;
            fft_load  <= 1'b0;
            fft_start <= 1'b0;
            fft_addr  <= '0;
            fft_re    <= '0;
            fft_im    <= '0;
        end else begin
            fft_load  <= 1'b0;
            fft_start <= 1'b0;
            inflight  <= fft_en_out;
            if (accept) begin
                fft_load <= 1'b1;
                fft_addr <= SIZE'(bitrev(32'(cnt), SIZE));
                fft_re   <= bus.s_re;
                fft_im   <= bus.s_im;
                cnt      <= cnt + 1'b1;
                state    <= (cnt == SIZE'(N-1)) ? START : LOAD;
            end
            case (state)
                START: begin
                    fft_start <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (fft_done) begin
                        state  <= UNLOAD;
                        cnt    <= '0;
                        issued <= '0;
                    end else if (wait_expired) begin
                        state <= IDLE;
                    end
                end
                UNLOAD: begin
                    if (fft_en_out) issued <= issued + 1'b1;
                    if (pop) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == SIZE'(N-1)) state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
